// File: rtl/code_sender.sv
// code_sender: transmit side of the on/off pulse-code link to the lock.
// A rising start edge loads code_in. Each bit is then sent MSB first as a
// PULSE_TICKS-long pulse on onpulse (bit=1) or offpulse (bit=0), followed
// by GAP_TICKS ticks with both lines low. A one-clock done strobe follows
// the last gap.
module code_sender #(
    parameter int CODE_LEN    = 5,
    parameter int PULSE_TICKS = 1,
    parameter int GAP_TICKS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                abort,
    input  logic [CODE_LEN-1:0] code_in,
    output logic                onpulse,
    output logic                offpulse,
    output logic                busy,
    output logic                done
);

    localparam int MAX_TICKS = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int SW        = $clog2(CODE_LEN + 1);

    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [SW-1:0] SYM_LOAD   = SW'(CODE_LEN);
    localparam logic [SW-1:0] SYM_ONE    = SW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                s1;
    logic                s2;
    logic                s3;
    logic                start_req;

    logic [CODE_LEN-1:0] shreg;
    logic [TW-1:0]       tick_cnt;
    logic [SW-1:0]       sym_cnt;

    // Control strobes from the next-state logic into the datapath.
    logic                load;
    logic                pulse_end;
    logic                gap_end;
    logic                in_seq;

    // start is asynchronous: two flops for metastability, a third to find the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= start;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start_req = s2 & ~s3;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, datapath strobes and output decode (outputs depend on state only).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pulse_end = 1'b0;
        gap_end   = 1'b0;
        in_seq    = (state == PULSE) || (state == GAP);
        onpulse   = (state == PULSE) &&  shreg[CODE_LEN-1];
        offpulse  = (state == PULSE) && !shreg[CODE_LEN-1];
        busy      = in_seq;
        done      = (state == DONE);

        if (abort) begin
            // Cancel wins over everything, including a start_req this cycle.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        load      = 1'b1;
                        state_nxt = PULSE;
                    end
                end
                PULSE: begin
                    if (tick && (tick_cnt == PULSE_LAST)) begin
                        pulse_end = 1'b1;
                        state_nxt = GAP;
                    end
                end
                GAP: begin
                    if (tick && (tick_cnt == GAP_LAST)) begin
                        gap_end   = 1'b1;
                        state_nxt = (sym_cnt == SYM_ONE) ? DONE : PULSE;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Shift register and counters; code_in is only looked at on load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            tick_cnt <= '0;
            sym_cnt  <= '0;
        end else if (abort) begin
            shreg    <= '0;
            tick_cnt <= '0;
            sym_cnt  <= '0;
        end else if (load) begin
            shreg    <= code_in;
            tick_cnt <= '0;
            sym_cnt  <= SYM_LOAD;
        end else if (pulse_end) begin
            tick_cnt <= '0;
        end else if (gap_end) begin
            tick_cnt <= '0;
            shreg    <= shreg << 1;
            sym_cnt  <= sym_cnt - SYM_ONE;
        end else if (tick && in_seq) begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

endmodule

// File: tb/tb_code_sender.sv
// Bench for code_sender. A slot-level model expands each loaded code into a
// per-tick schedule and is compared with both DUT instances every cycle.
// Directed tests add hand-computed literal expectations on top of that.
module tb_code_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, tick0, abort0;
    logic [4:0] code0;
    logic       on0, off0, busy0, done0;
    logic       start1, tick1, abort1;
    logic [1:0] code1;
    logic       on1, off1, busy1, done1;

    code_sender u0 (
        .clk(clk), .rst(rst), .tick(tick0), .start(start0), .abort(abort0),
        .code_in(code0), .onpulse(on0), .offpulse(off0), .busy(busy0), .done(done0)
    );

    code_sender #(.CODE_LEN(2), .PULSE_TICKS(2), .GAP_TICKS(1)) u1 (
        .clk(clk), .rst(rst), .tick(tick1), .start(start1), .abort(abort1),
        .code_in(code1), .onpulse(on1), .offpulse(off1), .busy(busy1), .done(done1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tick for u1: one clock in four while enabled.
    bit tick1_run = 1'b0;
    int tdiv = 0;
    always @(negedge clk) begin
        tdiv  <= (tdiv + 1) % 4;
        tick1 <= tick1_run && (tdiv == 3);
    end

    // ---------------- model ----------------
    // ph: 0 idle, 1 sending, 2 done strobe. A transmission is a list of tick
    // slots (1=on, 2=off, 0=low); each tick consumes one slot.
    localparam int CL [2] = '{5, 2};
    localparam int PT [2] = '{1, 2};
    localparam int GT [2] = '{1, 1};

    int ph [2];
    int pos [2];
    int len [2];
    int sched [2][16];
    bit prv [2];
    bit p1 [2];
    bit p0 [2];

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; pos[i] = 0; len[i] = 0;
            prv[i] = 1'b0; p1[i] = 1'b0; p0[i] = 1'b0;
        end
    endtask

    task automatic mstep(input int i, input logic st, input logic tk, input logic ab,
                         input logic [4:0] cd);
        bit ld;
        // A start rise seen at edge n becomes a load at edge n+2.
        ld     = p0[i];
        p0[i]  = p1[i];
        p1[i]  = st && !prv[i];
        prv[i] = st;
        if (ab) begin
            ph[i] = 0;
        end else if (ph[i] == 0) begin
            if (ld) begin
                len[i] = 0;
                pos[i] = 0;
                for (int b = CL[i] - 1; b >= 0; b--) begin
                    for (int t = 0; t < PT[i]; t++) begin
                        sched[i][len[i]] = cd[b] ? 1 : 2;
                        len[i]++;
                    end
                    for (int t = 0; t < GT[i]; t++) begin
                        sched[i][len[i]] = 0;
                        len[i]++;
                    end
                end
                ph[i] = 1;
            end
        end else if (ph[i] == 1) begin
            if (tk) begin
                pos[i]++;
                if (pos[i] == len[i]) ph[i] = 2;
            end
        end else begin
            ph[i] = 0;
        end
    endtask

    // Expected {busy, done, onpulse, offpulse}.
    function automatic logic [3:0] mexp(input int i);
        if (ph[i] == 1) return {1'b1, 1'b0, sched[i][pos[i]] == 1, sched[i][pos[i]] == 2};
        if (ph[i] == 2) return 4'b0100;
        return 4'b0000;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) mreset();
        else begin
            mstep(0, start0, tick0, abort0, code0);
            mstep(1, start1, tick1, abort1, {3'b000, code1});
        end
    end

    // Compare process: both instances every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("model u0", {28'd0, busy0, done0, on0, off0}, {28'd0, mexp(0)});
            chk("model u1", {28'd0, busy1, done1, on1, off1}, {28'd0, mexp(1)});
        end
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] tr [0:63];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run0(input int n);
        tr[0] = 4'b0000;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tr[k] = {busy0, done0, on0, off0};
        end
    endtask

    initial begin
        int on_first, on_last, off_first, off_last, dn, dn_idx, rises, offs, joined, nz;
        rst = 1'b0;
        start0 = 1'b0; tick0 = 1'b1; abort0 = 1'b0; code0 = 5'b0;
        start1 = 1'b0; abort1 = 1'b0; code1 = 2'b0;
        cyc(2);
        chk("reset u0", {28'd0, busy0, done0, on0, off0}, 32'd0);
        chk("reset u1", {28'd0, busy1, done1, on1, off1}, 32'd0);
        rst = 1'b1;
        cyc(2);

        // Nominal 00001, tick tied high.
        code0 = 5'b00001; start0 = 1'b1;
        run0(14);
        chk("nom +2 idle", tr[2], 4'b0000);
        chk("nom +3 off", tr[3], 4'b1001);
        chk("nom +4 gap", tr[4], 4'b1000);
        chk("nom +5 off", tr[5], 4'b1001);
        chk("nom +7 off", tr[7], 4'b1001);
        chk("nom +9 off", tr[9], 4'b1001);
        chk("nom +11 on", tr[11], 4'b1010);
        chk("nom +12 gap", tr[12], 4'b1000);
        chk("nom +13 done", tr[13], 4'b0100);
        chk("nom +14 idle", tr[14], 4'b0000);
        start0 = 1'b0;
        cyc(3);

        // Tick-gated on u1: code 10, pulses 2 ticks, gap 1 tick, tick every 4 clk.
        tick1_run = 1'b1; code1 = 2'b10; start1 = 1'b1;
        on_first = -1; on_last = -1; off_first = -1; off_last = -1; dn = 0; dn_idx = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (on1)  begin if (on_first < 0) on_first = k; on_last = k; end
            if (off1) begin if (off_first < 0) off_first = k; off_last = k; end
            if (done1) begin dn++; dn_idx = k; end
        end
        chk("gated off width", off_last - off_first + 1, 8);
        chk("gated gap1", off_first - on_last - 1, 4);
        chk("gated gap2", dn_idx - off_last - 1, 4);
        chk("gated first width ok", ((on_last - on_first + 1) >= 4) && ((on_last - on_first + 1) <= 8), 1);
        chk("gated done count", dn, 1);
        start1 = 1'b0; tick1_run = 1'b0;
        cyc(3);

        // All ones: five distinct on pulses, no off.
        code0 = 5'b11111; start0 = 1'b1;
        run0(16);
        rises = 0; offs = 0; dn = 0; joined = 0;
        for (int k = 1; k <= 16; k++) begin
            if (tr[k][1] && !tr[k-1][1]) rises++;
            if (tr[k][1] && tr[k-1][1]) joined++;
            if (tr[k][0]) offs++;
            if (tr[k][2]) dn++;
        end
        chk("ones on pulses", rises, 5);
        chk("ones merged pulses", joined, 0);
        chk("ones off count", offs, 0);
        chk("ones done count", dn, 1);
        start0 = 1'b0;
        cyc(3);

        // Busy rules: second start edge and code change during symbol 2.
        code0 = 5'b10110; start0 = 1'b1;
        tr[0] = 4'b0000; dn = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            tr[k] = {busy0, done0, on0, off0};
            if (done0) dn++;
            if (k == 4) start0 = 1'b0;
            if (k == 5) begin start0 = 1'b1; code0 = 5'b01001; end
        end
        chk("busy sym1 on", tr[3], 4'b1010);
        chk("busy sym2 off", tr[5], 4'b1001);
        chk("busy sym3 on", tr[7], 4'b1010);
        chk("busy sym4 on", tr[9], 4'b1010);
        chk("busy sym5 off", tr[11], 4'b1001);
        chk("busy done", tr[13], 4'b0100);
        chk("busy done count", dn, 1);
        start0 = 1'b0;
        cyc(3);

        // Abort during symbol 3, then a clean 11000.
        code0 = 5'b10101; start0 = 1'b1;
        run0(7);
        chk("abort sym3 on", tr[7], 4'b1010);
        abort0 = 1'b1;
        @(negedge clk);
        chk("abort clears", {28'd0, busy0, done0, on0, off0}, 32'd0);
        abort0 = 1'b0; start0 = 1'b0;
        nz = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy0 || done0) nz++;
        end
        chk("abort no done", nz, 0);
        code0 = 5'b11000; start0 = 1'b1;
        run0(14);
        chk("post abort s1 on", tr[3], 4'b1010);
        chk("post abort s2 on", tr[5], 4'b1010);
        chk("post abort s3 off", tr[7], 4'b1001);
        chk("post abort s4 off", tr[9], 4'b1001);
        chk("post abort s5 off", tr[11], 4'b1001);
        chk("post abort done", tr[13], 4'b0100);
        start0 = 1'b0;
        cyc(3);

        // Async reset while onpulse is high.
        code0 = 5'b11111; start0 = 1'b1;
        run0(3);
        chk("rst pre on", tr[3], 4'b1010);
        #2;
        rst = 1'b0; start0 = 1'b0;
        #1;
        chk("rst async", {28'd0, busy0, done0, on0, off0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run0(10);
        nz = 0;
        for (int k = 1; k <= 10; k++) if (tr[k] != 4'b0000) nz++;
        chk("rst stays idle", nz, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_sender.md
Name: code_sender

Overview:
- Transmit side of the on/off pulse-code interface used by the combination lock.
- On a start request, emits a programmable code as a sequence of one-symbol pulses on onpulse/offpulse, with a mandatory low gap between symbols, then flags completion.
- Sits in the user/test-stimulus path and drives the lock's pulse inputs directly.
- Advancement is gated by a tick strobe from the design's clock divider.

Parameters:
- CODE_LEN, 5, number of symbols per code.
- PULSE_TICKS, 1, ticks each symbol pulse is held high (>=1).
- GAP_TICKS, 1, ticks both outputs are held low after each symbol (>=1).

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- rst  input  1  asynchronous reset, active-low.
- tick  input  1  single-cycle advance strobe; tie high for one-symbol-per-clk timing.
- start  input  1  asynchronous level; a rising edge requests one transmission.
- abort  input  1  synchronous cancel, active-high.
- code_in  input  CODE_LEN  code to send, MSB first; 1 = on symbol, 0 = off symbol.
- onpulse  output  1  high while an on symbol is being sent.
- offpulse  output  1  high while an off symbol is being sent.
- busy  output  1  high from sequence load until DONE.
- done  output  1  one-clk strobe when a full code has been sent.

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters, shift register and sync flops =0; onpulse=offpulse=busy=done=0 immediately.
- Start synchronizer:
  - start passes through two flops, s1 then s2; s3 holds the previous s2.
  - start_req = s2 & ~s3, asserted for one clk.
  - start_req asserts 2 clk edges after a rising edge of start.
- States: IDLE, PULSE, GAP, DONE (2-bit register).
- IDLE: on start_req, load shreg<=code_in, sym_cnt<=CODE_LEN, tick_cnt<=0, busy<=1, state<=PULSE. Start is not tick-gated.
- PULSE:
  - onpulse = shreg[MSB], offpulse = ~shreg[MSB]. Both decode registered state only; never both high.
  - Each tick increments tick_cnt.
  - On a tick with tick_cnt==PULSE_TICKS-1: tick_cnt<=0, state<=GAP.
- GAP:
  - Both outputs low; ticks counted the same way up to GAP_TICKS-1.
  - On the terminating tick, shreg shifts left by 1 and sym_cnt decrements.
  - If sym_cnt was 1, go to DONE; else go to PULSE.
- DONE: done=1 and busy=0 for exactly one clk, then IDLE. done and busy are never high in the same cycle.
- Latency with tick tied high and defaults: first pulse 3 clk after the start edge; each symbol 2 clk (1 high, 1 low); done 13 clk after the start edge.
- Boundary conditions:
  - start_req while not in IDLE is ignored, with no queueing.
  - code_in is sampled only at load; later changes have no effect on the current sequence.
  - abort=1 in any state: next edge goes to IDLE, outputs low, busy=0, counters cleared, no done.
  - abort has priority over start_req in the same cycle.
  - tick during IDLE/DONE is ignored.
  - Consecutive identical symbols are always separated by >=GAP_TICKS ticks low, so the receiver sees distinct pulses.
  - rst asserted mid-sequence: immediate return to reset values; the sequence does not resume after rst deasserts.
  - First PULSE interval is between PULSE_TICKS-1 and PULSE_TICKS tick periods depending on tick alignment; all later intervals are exact.
- Widths: tick_cnt width = clog2(max(PULSE_TICKS,GAP_TICKS)+1); sym_cnt width = clog2(CODE_LEN+1).

Test Plan:
- Reset: drive rst=0 while in PULSE with onpulse=1 -> onpulse, busy and done go 0 without waiting for a clk edge; after rst=1, stays IDLE until a new start edge.
- Nominal: defaults, tick=1, code_in=5'b00001, start rises -> offpulse high 1 clk at edge+3, +5, +7, +9; onpulse high 1 clk at +11; lows between; done=1 at +13; busy high from +3 through +12.
- Tick-gated: tick every 4th clk, PULSE_TICKS=2, GAP_TICKS=1, code_in=5'b10 with CODE_LEN=2 -> second symbol offpulse high exactly 8 clk; gaps exactly 4 clk; one done strobe.
- All-ones: code_in=5'b11111 -> five separate onpulse pulses each followed by >=1 clk low; offpulse never asserts.
- Busy rules: second start edge and a code_in change during symbol 2 -> sequence unchanged, exactly one done.
- Abort: assert abort during symbol 3 -> outputs 0 and busy 0 next clk, no done. A subsequent start with code_in=5'b11000 -> on,on,off,off,off sent correctly.
